// File: rtl/note_tone_gen.sv
`default_nettype none
// =============================================================================
// note_tone_gen : square-wave tone generator with attack/sustain/release
//                 envelope, emitting signed 24-bit PCM over valid/ready.
// Revision      : 1.0
// =============================================================================
module note_tone_gen #(
   parameter int          SAMPLE_DIV   = 1042,
   parameter logic [15:0] ATTACK_STEP  = 16'd64,
   parameter logic [15:0] RELEASE_STEP = 16'd16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] half_period,
   input  logic        gate,
   output logic [23:0] sample,
   output logic        sample_valid,
   input  logic        sample_ready,
   output logic        overrun,
   output logic [1:0]  env_state
);

   localparam int               DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ATTACK  = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } env_t;

   env_t             r_state;
   logic [15:0]      r_amp;
   logic [DIV_W-1:0] r_div;
   logic [31:0]      r_hp_l;
   logic [31:0]      r_cnt;
   logic             r_phase;

   logic             w_tick;
   logic             w_retrig;
   logic             w_toggle;
   logic [16:0]      w_att_sum;
   logic [15:0]      w_att_amp;
   logic [15:0]      w_rel_amp;
   logic [23:0]      w_mag;

   assign w_tick    = (r_div == DIV_LAST);
   assign w_retrig  = w_tick && (r_state == IDLE) && gate;
   assign w_toggle  = (r_hp_l != 32'd0) && (r_cnt >= r_hp_l - 32'd1);
   assign w_att_sum = {1'b0, r_amp} + {1'b0, ATTACK_STEP};
   assign w_att_amp = w_att_sum[16] ? 16'hFFFF : w_att_sum[15:0];
   assign w_rel_amp = (r_amp > RELEASE_STEP) ? (r_amp - RELEASE_STEP) : 16'd0;
   assign w_mag     = {1'b0, r_amp, 7'b0};
   assign env_state = r_state;

   // Sample-rate divider and oscillator; the latched half-period only follows
   // the input at a toggle (or while zero) so frequency changes never glitch.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div   <= '0;
         r_hp_l  <= 32'd0;
         r_cnt   <= 32'd0;
         r_phase <= 1'b1;
      end else begin
         r_div <= w_tick ? '0 : r_div + 1'b1;
         if (r_hp_l == 32'd0 || w_toggle)
            r_hp_l <= half_period;
         if (w_retrig) begin
            r_phase <= 1'b1;
            r_cnt   <= 32'd0;
         end else if (r_hp_l == 32'd0) begin
            r_cnt   <= 32'd0;
         end else if (w_toggle) begin
            r_phase <= ~r_phase;
            r_cnt   <= 32'd0;
         end else begin
            r_cnt   <= r_cnt + 32'd1;
         end
      end
   end

   // Envelope FSM plus sample formation and output handshake, all on tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_amp        <= 16'd0;
         sample       <= 24'd0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else if (w_tick) begin
         sample       <= r_phase ? w_mag : -w_mag;
         sample_valid <= 1'b1;
         if (sample_valid && !sample_ready)
            overrun <= 1'b1;
         case (r_state)
            IDLE: begin
               if (gate) r_state <= ATTACK;
            end
            ATTACK: begin
               if (!gate) begin
                  r_state <= RELEASE;
               end else begin
                  r_amp <= w_att_amp;
                  if (w_att_amp == 16'hFFFF) r_state <= SUSTAIN;
               end
            end
            SUSTAIN: begin
               if (!gate) r_state <= RELEASE;
            end
            RELEASE: begin
               if (gate) begin
                  r_state <= ATTACK;
               end else begin
                  r_amp <= w_rel_amp;
                  if (w_rel_amp == 16'd0) r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end else if (sample_valid && sample_ready) begin
         sample_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_note_tone_gen.sv
`default_nettype none
// =============================================================================
// tb_note_tone_gen : directed self-checking bench for note_tone_gen
//                    (SAMPLE_DIV=4, ATTACK_STEP=4000h, RELEASE_STEP=8000h).
// Revision         : 1.0
// =============================================================================
module tb_note_tone_gen;

   logic        clk;
   logic        reset;
   logic [31:0] half_period;
   logic        gate;
   logic [23:0] sample;
   logic        sample_valid;
   logic        sample_ready;
   logic        overrun;
   logic [1:0]  env_state;

   int checks = 0;
   int fails  = 0;
   int edge_n = 0;

   note_tone_gen #(
      .SAMPLE_DIV   (4),
      .ATTACK_STEP  (16'h4000),
      .RELEASE_STEP (16'h8000)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .half_period  (half_period),
      .gate         (gate),
      .sample       (sample),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun),
      .env_state    (env_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // edge_n counts edges since the last reset edge; ticks land on multiples of 4.
   task automatic step();
      @(posedge clk);
      if (reset) edge_n = 0;
      else       edge_n++;
      #1;
   endtask

   task automatic run_to_edge(input int n);
      while (edge_n < n) step();
   endtask

   task automatic do_reset(input logic [31:0] hp);
      reset        = 1'b1;
      half_period  = hp;
      gate         = 1'b0;
      sample_ready = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      gate         = 1'b1;
      half_period  = 32'd100;
      sample_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (sample !== 24'd0 || sample_valid !== 1'b0 || overrun !== 1'b0 || env_state !== 2'd0) begin
            fails++;
            $display("FAIL reset cyc%0d: sample=%h valid=%b overrun=%b env=%0d, expected 0/0/0/0",
                     i, sample, sample_valid, overrun, env_state);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_attack_sustain();
      logic [23:0] exp_s [6];
      logic [1:0]  exp_e [6];
      exp_s = '{24'h0, 24'h0, 24'h200000, 24'h400000, 24'h600000, 24'h7FFF80};
      exp_e = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
      do_reset(32'd1000);
      gate = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         run_to_edge(4 * k);
         checks++;
         if (sample !== exp_s[k-1] || env_state !== exp_e[k-1] || sample_valid !== 1'b1) begin
            fails++;
            $display("FAIL attack tick%0d: sample=%h env=%0d valid=%b, expected %h/%0d/1",
                     k, sample, env_state, sample_valid, exp_s[k-1], exp_e[k-1]);
         end
      end
      step();
      checks++;
      if (sample_valid !== 1'b0) begin
         fails++;
         $display("FAIL accept_clear: valid=%b expected 0", sample_valid);
      end
   endtask

   // Continues from SUSTAIN left by test_attack_sustain (tick 6 at edge 24).
   task automatic test_release();
      logic [23:0] exp_s [9];
      logic [1:0]  exp_e [9];
      exp_s = '{24'h7FFF80, 24'h7FFF80, 24'h3FFF80, 24'h3FFF80, 24'h5FFF80,
                24'h7FFF80, 24'h7FFF80, 24'h3FFF80, 24'h000000};
      exp_e = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
      for (int k = 7; k <= 15; k++) begin
         if (k == 7)  gate = 1'b0;
         if (k == 9)  gate = 1'b1;
         if (k == 12) gate = 1'b0;
         run_to_edge(4 * k);
         checks++;
         if (sample !== exp_s[k-7] || env_state !== exp_e[k-7]) begin
            fails++;
            $display("FAIL release tick%0d: sample=%h env=%0d, expected %h/%0d",
                     k, sample, env_state, exp_s[k-7], exp_e[k-7]);
         end
      end
   endtask

   task automatic test_oscillator();
      logic [23:0] exp_s [15];
      exp_s = '{24'h000000, 24'h000000, 24'h200000, 24'hC00000, 24'hA00000,
                24'h7FFF80, 24'h800080, 24'h7FFF80, 24'h800080, 24'h800080,
                24'h7FFF80, 24'h800080, 24'h7FFF80, 24'h7FFF80, 24'h7FFF80};
      do_reset(32'd3);
      gate = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         if (k == 6) begin
            run_to_edge(23);
            half_period = 32'd5;
         end
         if (k == 13) half_period = 32'd0;
         run_to_edge(4 * k);
         checks++;
         if (sample !== exp_s[k-1]) begin
            fails++;
            $display("FAIL osc tick%0d: sample=%h expected %h", k, sample, exp_s[k-1]);
         end
      end
   endtask

   task automatic test_handshake();
      do_reset(32'd1000);
      sample_ready = 1'b0;
      run_to_edge(4);
      checks++;
      if (sample_valid !== 1'b1 || overrun !== 1'b0) begin
         fails++;
         $display("FAIL hs_first: valid=%b overrun=%b, expected 1/0", sample_valid, overrun);
      end
      run_to_edge(8);
      checks++;
      if (sample_valid !== 1'b1 || overrun !== 1'b1) begin
         fails++;
         $display("FAIL hs_overrun: valid=%b overrun=%b, expected 1/1", sample_valid, overrun);
      end
      sample_ready = 1'b1;
      run_to_edge(9);
      checks++;
      if (sample_valid !== 1'b0 || overrun !== 1'b1) begin
         fails++;
         $display("FAIL hs_sticky: valid=%b overrun=%b, expected 0/1", sample_valid, overrun);
      end
      run_to_edge(12);
      checks++;
      if (sample_valid !== 1'b1 || overrun !== 1'b1) begin
         fails++;
         $display("FAIL hs_sticky2: valid=%b overrun=%b, expected 1/1", sample_valid, overrun);
      end
   endtask

   task automatic test_back_to_back();
      do_reset(32'd1000);
      gate         = 1'b1;
      sample_ready = 1'b0;
      run_to_edge(7);
      sample_ready = 1'b1;
      run_to_edge(8);
      checks++;
      if (sample_valid !== 1'b1 || overrun !== 1'b0) begin
         fails++;
         $display("FAIL same_cycle8: valid=%b overrun=%b, expected 1/0", sample_valid, overrun);
      end
      sample_ready = 1'b0;
      run_to_edge(11);
      sample_ready = 1'b1;
      run_to_edge(12);
      checks++;
      if (sample_valid !== 1'b1 || overrun !== 1'b0 || sample !== 24'h200000) begin
         fails++;
         $display("FAIL same_cycle12: valid=%b overrun=%b sample=%h, expected 1/0/200000",
                  sample_valid, overrun, sample);
      end
      run_to_edge(13);
      reset = 1'b1;
      step();
      checks++;
      if (env_state !== 2'd0 || sample !== 24'd0 || sample_valid !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: env=%0d sample=%h valid=%b, expected 0/0/0",
                  env_state, sample, sample_valid);
      end
      reset = 1'b0;
      run_to_edge(8);
      checks++;
      if (sample !== 24'd0 || env_state !== 2'd1) begin
         fails++;
         $display("FAIL amp_cleared: sample=%h env=%0d, expected 0/1", sample, env_state);
      end
   endtask

   initial begin
      reset        = 1'b1;
      gate         = 1'b0;
      half_period  = 32'd0;
      sample_ready = 1'b0;
      test_reset();
      test_attack_sustain();
      test_release();
      test_oscillator();
      test_handshake();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
